// File: rtl/irrigation_controller.sv
// rtl/irrigation_controller.sv - Irrigation tank/valve sequencing controller
//
// Synchronises and debounces the tank level probes, arbitrates sprinkler/drip
// requests, and drives the fill valve, sprinkler/drip valves, alarm and the
// display strobe that feeds the seven-segment decoder.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   h_raw       in   high-level probe (async, 1 = water present)
//   m_raw       in   medium-level probe (async)
//   l_raw       in   low-level probe (async)
//   as_req      in   sprinkler request (async level)
//   gt_req      in   drip request (async level)
//   h, m, l     out  debounced levels
//   As, Gt      out  sprinkler / drip valve on
//   fill_valve  out  tank fill valve on
//   alarm       out  inconsistent probes or fill timeout
//   pulse       out  one-cycle display update strobe
//   state       out  IDLE=00 FILL=01 IRRIG=10 ERROR=11
//
// Optional feature macro: FILL_TIMEOUT_EN (fill timeout with sticky ERROR).

module irrigation_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_PERIOD    = 8,
    parameter int FILL_TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       h_raw,
    input  logic       m_raw,
    input  logic       l_raw,
    input  logic       as_req,
    input  logic       gt_req,
    output logic       h,
    output logic       m,
    output logic       l,
    output logic       As,
    output logic       Gt,
    output logic       fill_valve,
    output logic       alarm,
    output logic       pulse,
    output logic [1:0] state
);

    if (DEBOUNCE_CYCLES < 1 || PULSE_PERIOD < 2 || FILL_TIMEOUT < 1) begin : g_bad_params
        $fatal(1, "irrigation_controller: parameter out of range");
    end

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RCW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int PCW = $clog2(PULSE_PERIOD);
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RDY_LAST = RCW'(DEBOUNCE_CYCLES + 1);
    localparam logic [PCW-1:0] P_LAST   = PCW'(PULSE_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_IRRIG = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    // Bit order in the sync pipeline: {h, m, l, as, gt}
    logic [4:0]          sync1_q, sync2_q;
    logic [2:0]          lvl_q, lvl_d;            // {h, m, l}
    logic [2:0][DCW-1:0] db_cnt_q, db_cnt_d;
    logic [RCW-1:0]      rdy_cnt_q, rdy_cnt_d;
    logic                ready_q, ready_d;
    state_t              state_q, state_d;
    logic                as_q, as_d, gt_q, gt_d;
    logic                fill_q, fill_d, alarm_q, alarm_d;
    logic [4:0]          disp, disp_prev_q;
    logic                chg;
    logic [PCW-1:0]      pcnt_q, pcnt_d;
    logic                pulse_q, pulse_d;
    logic                invalid, sticky;

`ifdef FILL_TIMEOUT_EN
    localparam int TCW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(FILL_TIMEOUT - 1);
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           tmo_q, tmo_d;
    assign sticky = tmo_q;
`else
    assign sticky = 1'b0;
`endif

    // A level bit flips once DEBOUNCE_CYCLES consecutive synced samples
    // disagree with it; any agreeing sample restarts the count.
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i+2] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = sync2_q[i+2];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdy_cnt_d = rdy_cnt_q;
        ready_d   = ready_q;
        if (!ready_q) begin
            if (rdy_cnt_q == RDY_LAST) ready_d = 1'b1;
            else rdy_cnt_d = rdy_cnt_q + 1'b1;
        end
    end

    // The FSM looks at the levels as updated on this edge so a debounced
    // level change and the resulting state change land on the same edge.
    assign invalid = (lvl_d[2] & ~lvl_d[1]) | (lvl_d[1] & ~lvl_d[0]);

    always_comb begin
        state_d = state_q;
        as_d    = as_q;
        gt_d    = gt_q;
`ifdef FILL_TIMEOUT_EN
        tcnt_d  = '0;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ready_q) begin
                    if (invalid) state_d = S_ERROR;
                    else if (!lvl_d[0]) state_d = S_FILL;
                    else if (sync2_q[1] | sync2_q[0]) begin
                        state_d = S_IRRIG;
                        gt_d    = sync2_q[0];
                        as_d    = ~sync2_q[0];
                    end
                end
            end
            S_FILL: begin
                if (invalid) state_d = S_ERROR;
                else if (lvl_d[2]) state_d = S_IDLE;
`ifdef FILL_TIMEOUT_EN
                else if (tcnt_q == T_LAST) begin
                    state_d = S_ERROR;
                    tmo_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            S_IRRIG: begin
                if (invalid) state_d = S_ERROR;
                else if (!lvl_d[0]) state_d = S_FILL;
                else if (gt_q ? !sync2_q[0] : !sync2_q[1]) state_d = S_IDLE;
            end
            default: begin
                if (!invalid && !sticky) state_d = S_IDLE;
            end
        endcase
        if (state_d != S_IRRIG) begin
            as_d = 1'b0;
            gt_d = 1'b0;
        end
        fill_d  = (state_d == S_FILL);
        alarm_d = (state_d == S_ERROR);
    end

    // Forced strobe one cycle after any display-bit change, restarting the
    // periodic counter; coincident forced/periodic strobes merge.
    assign disp = {lvl_q, as_q, gt_q};
    assign chg  = (disp != disp_prev_q);

    always_comb begin
        pcnt_d  = (chg || pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
        pulse_d = chg || (pcnt_d == P_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            db_cnt_q    <= '0;
            rdy_cnt_q   <= '0;
            ready_q     <= 1'b0;
            state_q     <= S_IDLE;
            as_q        <= 1'b0;
            gt_q        <= 1'b0;
            fill_q      <= 1'b0;
            alarm_q     <= 1'b0;
            disp_prev_q <= '0;
            pcnt_q      <= '0;
            pulse_q     <= 1'b0;
`ifdef FILL_TIMEOUT_EN
            tcnt_q      <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            sync1_q     <= {h_raw, m_raw, l_raw, as_req, gt_req};
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            db_cnt_q    <= db_cnt_d;
            rdy_cnt_q   <= rdy_cnt_d;
            ready_q     <= ready_d;
            state_q     <= state_d;
            as_q        <= as_d;
            gt_q        <= gt_d;
            fill_q      <= fill_d;
            alarm_q     <= alarm_d;
            disp_prev_q <= disp;
            pcnt_q      <= pcnt_d;
            pulse_q     <= pulse_d;
`ifdef FILL_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign h          = lvl_q[2];
    assign m          = lvl_q[1];
    assign l          = lvl_q[0];
    assign As         = as_q;
    assign Gt         = gt_q;
    assign fill_valve = fill_q;
    assign alarm      = alarm_q;
    assign pulse      = pulse_q;
    assign state      = state_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// tb/tb_irrigation_controller.sv - Self-checking bench for irrigation_controller

module tb_irrigation_controller;

    localparam int DB = 4;
    localparam int PP = 8;
    localparam int FT = 64;
`ifdef FILL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic h_raw, m_raw, l_raw, as_req, gt_req;
    logic h, m, l, As, Gt, fill_valve, alarm, pulse;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    irrigation_controller #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_PERIOD(PP),
        .FILL_TIMEOUT(FT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .h_raw(h_raw), .m_raw(m_raw), .l_raw(l_raw),
        .as_req(as_req), .gt_req(gt_req),
        .h(h), .m(m), .l(l), .As(As), .Gt(Gt),
        .fill_valve(fill_valve), .alarm(alarm), .pulse(pulse), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Works from the history of raw inputs indexed by edge number n since
    // reset release: the synced sample seen at edge k is raw[k-2].
    logic [4:0] raw_hist [0:2047];
    logic [4:0] out_hist [0:2047];
    int n, r, fc;
    bit sticky;
    logic [1:0] e_state, ns;
    logic [2:0] e_lvl;
    logic e_as, e_gt, e_fill, e_alarm, e_pulse, inval, mv, msame;
    logic [4:0] ms, req, o1, o2;

    function automatic logic [4:0] rawat(input int k);
        return (k < 1) ? 5'b0 : raw_hist[k];
    endfunction

    function automatic logic [4:0] outat(input int k);
        return (k < 1) ? 5'b0 : out_hist[k];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0; r = 0; fc = 0; sticky = 0;
            e_state = 2'b00; e_lvl = 3'b000;
            e_as = 0; e_gt = 0; e_fill = 0; e_alarm = 0; e_pulse = 0;
        end else if (n < 2040) begin
            n = n + 1;
            raw_hist[n] = {h_raw, m_raw, l_raw, as_req, gt_req};
            // a level flips when its last DB synced samples agree and differ from it
            for (int b = 0; b < 3; b++) begin
                ms = rawat(n - 2);
                mv = ms[b+2];
                msame = 1'b1;
                for (int j = 1; j < DB; j++) begin
                    ms = rawat(n - 2 - j);
                    if (ms[b+2] != mv) msame = 1'b0;
                end
                if (msame && mv != e_lvl[b]) e_lvl[b] = mv;
            end
            req = rawat(n - 2);
            inval = (e_lvl[2] & ~e_lvl[1]) | (e_lvl[1] & ~e_lvl[0]);
            ns = e_state;
            case (e_state)
                2'b00: if (n >= DB + 3) begin
                    if (inval) ns = 2'b11;
                    else if (!e_lvl[0]) ns = 2'b01;
                    else if (req[1] | req[0]) begin
                        ns = 2'b10; e_gt = req[0]; e_as = !req[0];
                    end
                end
                2'b01: begin
                    fc = fc + 1;
                    if (inval) ns = 2'b11;
                    else if (e_lvl[2]) ns = 2'b00;
                    else if (TMO_EN && fc >= FT) begin ns = 2'b11; sticky = 1; end
                end
                2'b10: begin
                    if (inval) ns = 2'b11;
                    else if (!e_lvl[0]) ns = 2'b01;
                    else if (e_gt ? !req[0] : !req[1]) ns = 2'b00;
                end
                default: if (!inval && !sticky) ns = 2'b00;
            endcase
            e_state = ns;
            if (ns != 2'b10) begin e_as = 0; e_gt = 0; end
            if (ns != 2'b01) fc = 0;
            e_fill = (ns == 2'b01);
            e_alarm = (ns == 2'b11);
            o1 = outat(n - 1);
            o2 = outat(n - 2);
            if (o1 != o2) r = n;
            e_pulse = (o1 != o2) || ((n - r) % PP == PP - 1);
            out_hist[n] = {e_lvl, e_as, e_gt};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({state, h, m, l, As, Gt, fill_valve, alarm, pulse} !==
                {e_state, e_lvl, e_as, e_gt, e_fill, e_alarm, e_pulse}) begin
                bad++;
                $display("FAIL model_cmp t=%0t n=%0d got{st,hml,As,Gt,fv,al,pu}=%b want=%b", $time, n,
                         {state, h, m, l, As, Gt, fill_valve, alarm, pulse},
                         {e_state, e_lvl, e_as, e_gt, e_fill, e_alarm, e_pulse});
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        h_raw = 1; m_raw = 1; l_raw = 1; as_req = 0; gt_req = 0;
        tick(3);
        chk_en = 1'b1;
        chk("reset_outs", {6'b0, state, h, m, l, As, Gt, fill_valve, alarm, pulse}, 16'h0);
        reset_n = 1'b1;

        // levels full at power-up
        tick(5); chk("lvl_before_lat", {h, m, l}, 3'b000);
        tick(1); chk("lvl_at_lat", {h, m, l}, 3'b111);
        chk("idle_full", state, 2'b00);
        tick(1); chk("forced_pulse_lvl", pulse, 1'b1);
        tick(6); chk("no_pulse_e13", pulse, 1'b0);
        tick(1); chk("periodic_e14", pulse, 1'b1);
        tick(8); chk("periodic_e22", pulse, 1'b1);
        tick(10);

        // empty tank, fill, refill step by step
        h_raw = 0; m_raw = 0; l_raw = 0;
        tick(5); chk("fill_pre", state, 2'b00);
        tick(1); chk("fill_enter", {state, fill_valve}, 3'b011);
        l_raw = 1; tick(10);
        m_raw = 1; tick(10);
        h_raw = 1;
        tick(5); chk("fill_hold", {state, fill_valve}, 3'b011);
        tick(1); chk("fill_done", {state, fill_valve}, 3'b000);
        tick(4);

        // both requests: drip wins, mode latched
        as_req = 1; gt_req = 1;
        tick(2); chk("irrig_pre", state, 2'b00);
        tick(1); chk("irrig_gt", {state, As, Gt}, 4'b1001);
        tick(1); chk("pulse_after_gt", pulse, 1'b1);
        as_req = 0; tick(8); chk("gt_keeps", {state, As, Gt}, 4'b1001);
        gt_req = 0;
        tick(2); chk("gt_drop_pre", state, 2'b10);
        tick(1); chk("gt_drop_idle", {state, Gt}, 3'b000);
        tick(4);

        // sprinkler with only the low probe wet, then glitch/hold on l
        h_raw = 0; tick(10);
        m_raw = 0; tick(10);
        as_req = 1;
        tick(3); chk("irrig_as", {state, As, Gt}, 4'b1010);
        tick(3);
        l_raw = 0; tick(3); l_raw = 1;
        tick(10); chk("glitch_ignored", {state, As}, 3'b101);
        l_raw = 0;
        tick(5); chk("l_low_pre", {state, As}, 3'b101);
        tick(1); chk("l_low_fill", {state, As, fill_valve}, 4'b0101);

        // inconsistent probes
        as_req = 0; h_raw = 1; m_raw = 0; l_raw = 1;
        tick(5); chk("err_pre", state, 2'b01);
        tick(1); chk("err_enter", {state, alarm, fill_valve}, 4'b1110);
        tick(4); m_raw = 1;
        tick(5); chk("err_hold", state, 2'b11);
        tick(1); chk("err_exit", {state, alarm}, 3'b000);

        // long fill: timeout only when the feature is built in
        h_raw = 0; m_raw = 0; l_raw = 0;
        tick(6); chk("long_fill_enter", state, 2'b01);
        tick(63); chk("long_fill_63", state, 2'b01);
        tick(1);
        if (TMO_EN) chk("tmo_err", {state, alarm}, 3'b111);
        else chk("no_tmo", {state, alarm}, 3'b010);
        h_raw = 1; m_raw = 1; l_raw = 1;
        tick(10);
        if (TMO_EN) chk("tmo_sticky", {state, alarm}, 3'b111);
        else chk("fill_to_idle", {state, alarm}, 3'b000);

        // async reset during operation
        as_req = 1;
        tick(4);
        if (!TMO_EN) chk("irrig_before_rst", {state, As}, 3'b101);
        reset_n = 1'b0;
        #1;
        chk("async_rst", {6'b0, state, h, m, l, As, Gt, fill_valve, alarm, pulse}, 16'h0);
        tick(2);
        reset_n = 1'b1;
        tick(7); chk("irrig_after_rst", {state, As, Gt}, 4'b1010);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
